// File: rtl/pr_csr_responder.sv
// CSR responder for the port-gasket partial-reconfiguration region: register decode,
// bitstream FIFO toward the PR engine and the PR handshake sequencer.
module pr_csr_responder #(
    parameter logic [63:0] DFH_VALUE  = 64'h3000_0000_1000_1005,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csr_wr,
    input  logic        csr_rd,
    input  logic [5:0]  csr_addr,
    input  logic [63:0] csr_wdata,
    output logic [63:0] csr_rdata,
    output logic        csr_rd_valid,
    output logic [31:0] pr_data,
    output logic        pr_data_valid,
    input  logic        pr_data_ready,
    output logic        pr_start,
    input  logic        pr_done,
    input  logic        pr_error
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam logic [PtrW:0] PtrOne = 1;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StActive   = 3'd1,
        StDrain    = 3'd2,
        StWaitDone = 3'd3,
        StDone     = 3'd4,
        StReset    = 3'd5
    } state_e;

    state_e        state_q, state_d;
    logic          ctrl_reset_q, ctrl_reset_d;
    logic          push_cmpl_q, push_cmpl_d;
    logic [3:0]    err_q, err_d;
    logic [15:0]   count_q, count_d;
    logic          pr_start_q, pr_start_d;
    logic          rd_valid_q, rd_valid_d;
    logic [63:0]   rdata_q, rdata_d;
    logic [PtrW:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]   mem_q [FIFO_DEPTH];

    logic       wr_ctrl, wr_data, wr_err;
    logic       fifo_empty, fifo_full;
    logic       push, pop, flush, pr_err_live;
    logic [3:0] err_set, err_clr;
    logic       reset_ack, pr_active;
    logic       unused_wdata;

    assign unused_wdata = ^csr_wdata[63:32];

    assign wr_ctrl = csr_wr && (csr_addr == 6'h08);
    assign wr_data = csr_wr && (csr_addr == 6'h18);
    assign wr_err  = csr_wr && (csr_addr == 6'h20);

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                        (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);

    assign pr_data_valid = !fifo_empty && (state_q != StReset);
    assign pr_data       = pr_data_valid ? mem_q[rd_ptr_q[PtrW-1:0]] : 32'h0;
    assign pop           = pr_data_valid && pr_data_ready;

    assign pr_err_live = pr_error && (state_q != StIdle) && (state_q != StReset);
    assign reset_ack   = (state_q == StReset) && fifo_empty;
    assign pr_active   = (state_q == StActive) || (state_q == StDrain) ||
                         (state_q == StWaitDone);

    assign pr_start     = pr_start_q;
    assign csr_rd_valid = rd_valid_q;
    assign csr_rdata    = rdata_q;

    always_comb begin
        state_d      = state_q;
        ctrl_reset_d = ctrl_reset_q;
        push_cmpl_d  = push_cmpl_q;
        count_d      = count_q;
        pr_start_d   = 1'b0;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        err_set      = 4'h0;
        push         = 1'b0;
        flush        = 1'b0;

        if (wr_ctrl) begin
            ctrl_reset_d = csr_wdata[0];
            if (csr_wdata[13]) begin
                push_cmpl_d = 1'b1;
            end
        end

        // Fullness is judged before this cycle's pop.
        if (wr_data) begin
            if (state_q != StActive) begin
                err_set[1] = 1'b1;
            end else if (fifo_full) begin
                err_set[0] = 1'b1;
            end else begin
                push = 1'b1;
            end
        end

        if (pr_err_live) begin
            err_set[2] = 1'b1;
        end

        if (ctrl_reset_d) begin
            state_d = StReset;
            flush   = 1'b1;
        end else if (pr_err_live) begin
            state_d = StIdle;
            flush   = 1'b1;
        end else begin
            if (wr_ctrl && csr_wdata[12]) begin
                if (state_q == StIdle || state_q == StDone) begin
                    state_d     = StActive;
                    pr_start_d  = 1'b1;
                    push_cmpl_d = 1'b0;
                    count_d     = 16'h0;
                end else begin
                    err_set[3] = 1'b1;
                end
            end
            case (state_q)
                StActive:   if (wr_ctrl && csr_wdata[13]) state_d = StDrain;
                StDrain:    if (fifo_empty) state_d = StWaitDone;
                StWaitDone: if (pr_done) state_d = StDone;
                StReset:    state_d = StIdle;
                default:    ;
            endcase
        end

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrOne;
                count_d  = count_q + 16'd1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrOne;
            end
        end

        // A set in the same cycle as a write-one-to-clear keeps the bit.
        err_clr = wr_err ? csr_wdata[3:0] : 4'h0;
        err_d   = (err_q & ~err_clr) | err_set;
    end

    always_comb begin
        rdata_d    = 64'h0;
        rd_valid_d = csr_rd;
        if (csr_rd) begin
            case (csr_addr)
                6'h00: rdata_d = DFH_VALUE;
                6'h08: begin
                    rdata_d[0]  = ctrl_reset_q;
                    rdata_d[4]  = reset_ack;
                    rdata_d[13] = push_cmpl_q;
                end
                6'h10: begin
                    rdata_d[2:0]   = state_q;
                    rdata_d[16]    = pr_active;
                    rdata_d[47:32] = count_q;
                end
                6'h20:   rdata_d[3:0] = err_q;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            ctrl_reset_q <= 1'b0;
            push_cmpl_q  <= 1'b0;
            err_q        <= 4'h0;
            count_q      <= 16'h0;
            pr_start_q   <= 1'b0;
            rd_valid_q   <= 1'b0;
            rdata_q      <= 64'h0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            state_q      <= state_d;
            ctrl_reset_q <= ctrl_reset_d;
            push_cmpl_q  <= push_cmpl_d;
            err_q        <= err_d;
            count_q      <= count_d;
            pr_start_q   <= pr_start_d;
            rd_valid_q   <= rd_valid_d;
            rdata_q      <= rdata_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[PtrW-1:0]] <= csr_wdata[31:0];
        end
    end

endmodule

// File: doc/pr_csr_responder.md
# pr_csr_responder

Responder side of the port-gasket partial-reconfiguration (PR) CSR region at PG_PR_DFH (0x70000). It decodes the host-driven CSR reads and writes for DFH, PR_CTRL, PR_STATUS, PR_DATA and PR_ERROR, and buffers PR bitstream words in a FIFO. It streams those words to the PR engine and sequences reset, start, data-push-complete and done handshakes through a state machine. It sits in the port gasket between the CSR decode fabric and the PR IP.

## Interface
- DFH_VALUE, 64'h3000_0000_1000_1005: constant returned at offset 0x00
- FIFO_DEPTH, 16: PR data FIFO entries, power of 2, ≥4
- clk  in  1  single clock domain
- rst  in  1  reset, synchronous, active-high
- csr_wr  in  1  write strobe, one cycle per access
- csr_rd  in  1  read strobe, one cycle per access
- csr_addr  in  6  byte offset within region; 0x00/0x08/0x10/0x18/0x20 decoded, others ignored
- csr_wdata  in  64  write data
- csr_rdata  out  64  read data
- csr_rd_valid  out  1  read response strobe
- pr_data  out  32  bitstream word to PR engine
- pr_data_valid  out  1  word valid
- pr_data_ready  in  1  PR engine accepts word
- pr_start  out  1  one-cycle pulse to PR engine
- pr_done  in  1  one-cycle pulse, PR finished OK
- pr_error  in  1  one-cycle pulse, PR failed

## Operation
- Registers:
  - 0x00 DFH: read-only DFH_VALUE.
  - 0x08 PR_CTRL:
    - bit0 PRReset: RW.
    - bit4 PRReset_ack: RO, 1 while in RESET with FIFO empty.
    - bit12 PRStartRequest: W1, reads 0.
    - bit13 PRDataPushComplete: W1S, cleared on entering ACTIVE.
    - Other bits read 0.
  - 0x10 PR_STATUS, RO:
    - [2:0] state code.
    - bit16 PRStatus: 1 in ACTIVE/DRAIN/WAIT_DONE.
    - [47:32] words-pushed count, 16-bit, wraps 0xFFFF→0, cleared on entering ACTIVE.
  - 0x18 PR_DATA: write pushes csr_wdata[31:0] into the FIFO. Reads return 0.
  - 0x20 PR_ERROR, W1C:
    - bit0 fifo overflow.
    - bit1 data written outside ACTIVE.
    - bit2 pr_error seen.
    - bit3 start request while not IDLE/DONE.
- FSM, codes in parentheses:
  - IDLE(0): start request → ACTIVE; pr_start pulses the cycle after the write.
  - ACTIVE(1): accepts PR_DATA. Writing PRDataPushComplete → DRAIN.
  - DRAIN(2): FIFO empty → WAIT_DONE.
  - WAIT_DONE(3): pr_done → DONE. pr_error → IDLE, sets bit2.
  - DONE(4): start request → ACTIVE.
  - RESET(5): entered from any state when PRReset=1. Flushes the FIFO and holds pr_data_valid low. PRReset cleared → IDLE.
- pr_error in any state other than IDLE/RESET sets bit2 and returns the FSM to IDLE. Any FIFO contents are flushed.
- PR_DATA write outside ACTIVE: word dropped, bit1 set.
- PR_DATA write in ACTIVE with FIFO full: word dropped, bit0 set. Full is evaluated before the same-cycle pop, so a simultaneous pop does not make room.
- The words-pushed count increments on each accepted FIFO push.
- Start request outside IDLE/DONE: ignored, bit3 set.
- Error-bit set and W1C in the same cycle: set wins.
- PRReset=1 and start request in the same write: reset wins, start is ignored and bit3 is not set.
- FIFO pop occurs when pr_data_valid && pr_data_ready. pr_data_valid equals FIFO not-empty outside RESET.

## Timing
- rst: all outputs 0, FSM IDLE, FIFO empty, all registers and counts 0.
- Writes take effect at the next clock edge. State and flags are visible to a read issued the cycle after the write.
- Reads: csr_rd_valid and csr_rdata are registered and appear exactly 1 cycle after csr_rd. csr_rdata is 0 when csr_rd_valid is 0.
- A read returns the value from before any same-cycle write.
- csr_rd and csr_wr may assert together; each is processed as if alone.
- FIFO push to pr_data_valid latency: 1 cycle when empty.
- Full throughput is one word per cycle on each side.
- PRReset_ack rises no earlier than 1 cycle after PRReset is set, and no earlier than the FIFO becoming empty.
- pr_start is exactly 1 cycle wide.
- Mid-transfer reset: the cycle after PRReset is written, pr_data_valid=0, the FIFO is empty and the state is RESET.

## Test plan
- Reset, then read all five offsets → 0x00=DFH_VALUE, other offsets 0; each csr_rd_valid arrives 1 cycle after its csr_rd.
- Normal flow:
  - Stimulus: start, push 0x1..0x8 with pr_data_ready=1, PushComplete, then pr_done.
  - Response: pr_start pulse, words 0x1..0x8 out in order, states 1→2→3→4, STATUS[47:32]=8, PR_ERROR=0.
- Overflow: pr_data_ready=0, push 17 words with FIFO_DEPTH=16 → 16 words held, PR_ERROR=0x1, count=16; write 0x1 to 0x20 → PR_ERROR=0.
- Reset mid-op: 5 words queued, write PRReset=1 → next cycle pr_data_valid=0 and state=5, then ack bit4=1; clear PRReset → IDLE.
- Illegal accesses:
  - PR_DATA write in IDLE → PR_ERROR=0x2.
  - Start request in ACTIVE → bit3 set, no pr_start pulse.
- pr_error in WAIT_DONE → PR_ERROR bit2=1, state=0, next start is accepted.
